io_port_bank: RTL and testbench

Parametrised memory-mapped I/O port bank that sits on the CPU data bus beside RAM. It replaces the fixed 16-in/16-out, 8-bit port decode with configurable width, port counts and base addresses. It adds input synchronisers, per-input change-detect sticky flags, an interrupt mask and a registered interrupt request. The top level muxes its data_out onto the CPU read path when hit is high.

---
 rtl/io_port_bank_if.sv | 17 +
 rtl/io_port_bank.sv | 154 +++++++++++++++
 tb/tb_io_port_bank.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/io_port_bank_if.sv
// CPU data-bus connection for io_port_bank: address/write-data/strobe from the CPU,
// and registered read data plus a hit flag going back to it.
interface io_port_bank_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  // There is no valid/ready pair. The block accepts write as a one-cycle strobe on every
  // rising edge. The address presented at edge N produces data_out and hit after edge N.
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] data_in;
  logic              write;
  logic [DATA_W-1:0] data_out;
  logic              hit;

  modport master (output address, data_in, write, input data_out, hit);
  modport slave  (input address, data_in, write, output data_out, hit);
endinterface

// File: rtl/io_port_bank.sv
// Memory-mapped I/O port bank: output registers, synchronised inputs with change-detect
// sticky flags, an interrupt mask and a registered interrupt request.
module io_port_bank #(
  parameter int              DATA_W    = 8,
  parameter int              ADDR_W    = 8,
  parameter int              N_OUT     = 16,
  parameter int              N_IN      = 16,
  parameter logic [ADDR_W-1:0] OUT_BASE  = 8'hE0,
  parameter logic [ADDR_W-1:0] IN_BASE   = 8'hF0,
  parameter logic [ADDR_W-1:0] FLAG_BASE = 8'hD0,
  parameter logic [ADDR_W-1:0] MASK_BASE = 8'hD8
) (
  input  logic                     clk,
  input  logic                     reset,
  io_port_bank_if.slave            bus,
  input  logic [N_IN*DATA_W-1:0]   port_in,
  output logic [N_OUT*DATA_W-1:0]  port_out,
  output logic                     irq
);

  localparam int NW     = (N_IN + DATA_W - 1) / DATA_W;
  localparam int FW     = NW * DATA_W;
  localparam int OUT_IW = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam int IN_IW  = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int WI_W   = (NW > 1) ? $clog2(NW) : 1;

  localparam logic [ADDR_W:0] N_OUT_L = (ADDR_W+1)'(N_OUT);
  localparam logic [ADDR_W:0] N_IN_L  = (ADDR_W+1)'(N_IN);
  localparam logic [ADDR_W:0] NW_L    = (ADDR_W+1)'(NW);

  // One extra bit makes an address below the base wrap above every legal region size.
  logic [ADDR_W:0] out_off, in_off, flag_off, mask_off;
  assign out_off  = {1'b0, bus.address} - {1'b0, OUT_BASE};
  assign in_off   = {1'b0, bus.address} - {1'b0, IN_BASE};
  assign flag_off = {1'b0, bus.address} - {1'b0, FLAG_BASE};
  assign mask_off = {1'b0, bus.address} - {1'b0, MASK_BASE};

  logic hit_out, hit_in, hit_flag, hit_mask;
  assign hit_out  = out_off  < N_OUT_L;
  assign hit_in   = in_off   < N_IN_L;
  assign hit_flag = flag_off < NW_L;
  assign hit_mask = mask_off < NW_L;

  logic sel_out, sel_flag, sel_mask;
  assign sel_out  = hit_out;
  assign sel_flag = hit_flag & ~hit_out & ~hit_in;
  assign sel_mask = hit_mask & ~hit_out & ~hit_in & ~hit_flag;

  logic [OUT_IW-1:0] out_idx;
  logic [IN_IW-1:0]  in_idx;
  logic [WI_W-1:0]   flag_idx, mask_idx;
  assign out_idx  = out_off[OUT_IW-1:0];
  assign in_idx   = in_off[IN_IW-1:0];
  assign flag_idx = flag_off[WI_W-1:0];
  assign mask_idx = mask_off[WI_W-1:0];

  logic [DATA_W-1:0] out_r [N_OUT];

  for (genvar g = 0; g < N_OUT; g++) begin : g_out
    assign port_out[g*DATA_W +: DATA_W] = out_r[g];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_OUT; i++) out_r[i] <= '0;
    end else if (bus.write && sel_out) begin
      out_r[out_idx] <= bus.data_in;
    end
  end

  logic [N_IN*DATA_W-1:0] s1, s2, p;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1 <= '0;
      s2 <= '0;
      p  <= '0;
    end else begin
      s1 <= port_in;
      s2 <= s1;
      p  <= s2;
    end
  end

  // Flag/mask bits at or above N_IN are held at zero through the valid vector.
  logic [FW-1:0] chg, valid;
  for (genvar g = 0; g < FW; g++) begin : g_bits
    if (g < N_IN) begin : g_live
      assign chg[g]   = s2[g*DATA_W +: DATA_W] != p[g*DATA_W +: DATA_W];
      assign valid[g] = 1'b1;
    end else begin : g_pad
      assign chg[g]   = 1'b0;
      assign valid[g] = 1'b0;
    end
  end

  logic [FW-1:0] flags, mask, clr;

  always_comb begin
    clr = '0;
    if (bus.write && sel_flag) clr[flag_idx*DATA_W +: DATA_W] = bus.data_in;
  end

  // A change event on the same edge as its write-1-to-clear keeps the flag set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flags <= '0;
    end else begin
      flags <= (chg | (flags & ~clr)) & valid;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mask <= '0;
    end else if (bus.write && sel_mask) begin
      mask[mask_idx*DATA_W +: DATA_W] <= bus.data_in & valid[mask_idx*DATA_W +: DATA_W];
    end
  end

  logic [DATA_W-1:0] rd_data;
  logic              rd_hit;

  always_comb begin
    rd_data = '0;
    rd_hit  = 1'b0;
    if (hit_out) begin
      rd_hit  = 1'b1;
      rd_data = out_r[out_idx];
    end else if (hit_in) begin
      rd_hit  = 1'b1;
      rd_data = s2[in_idx*DATA_W +: DATA_W];
    end else if (hit_flag) begin
      rd_hit  = 1'b1;
      rd_data = flags[flag_idx*DATA_W +: DATA_W];
    end else if (hit_mask) begin
      rd_hit  = 1'b1;
      rd_data = mask[mask_idx*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.data_out <= '0;
      bus.hit      <= 1'b0;
      irq          <= 1'b0;
    end else begin
      bus.data_out <= rd_data;
      bus.hit      <= rd_hit;
      irq          <= |(flags & mask);
    end
  end

endmodule

// File: tb/tb_io_port_bank.sv
// Directed bench for io_port_bank: a default 8-bit instance plus a 16-bit, 20-input,
// 4-output instance for the parameter and reset cases.
module tb_io_port_bank;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  io_port_bank_if #(.ADDR_W(8), .DATA_W(8))  bus ();
  io_port_bank_if #(.ADDR_W(8), .DATA_W(16)) bus2 ();

  logic [127:0] port_in;
  logic [127:0] port_out;
  logic         irq;
  logic [319:0] port_in2;
  logic [63:0]  port_out2;
  logic         irq2;

  int errors = 0;
  int checks = 0;

  io_port_bank dut (
    .clk(clk), .reset(reset), .bus(bus),
    .port_in(port_in), .port_out(port_out), .irq(irq)
  );

  io_port_bank #(.DATA_W(16), .N_IN(20), .N_OUT(4)) dut2 (
    .clk(clk), .reset(reset), .bus(bus2),
    .port_in(port_in2), .port_out(port_out2), .irq(irq2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    port_in = '1;
    port_in2 = '0;
    bus2.address = 8'h00; bus2.data_in = '0; bus2.write = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.address = 8'($urandom_range(0, 255));
      bus.data_in = 8'($urandom_range(0, 255));
      bus.write   = 1'($urandom_range(0, 1));
      tick();
      checks++; if (port_out !== '0) begin errors++; $display("FAIL rst_port_out: got %0h expected 0", port_out); end
      checks++; if (bus.data_out !== 8'h00) begin errors++; $display("FAIL rst_data_out: got %0h expected 0", bus.data_out); end
      checks++; if (bus.hit !== 1'b0) begin errors++; $display("FAIL rst_hit: got %0b expected 0", bus.hit); end
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rst_irq: got %0b expected 0", irq); end
    end
    bus.write = 1'b0;
    bus.address = 8'hD0;
    reset = 1'b1;
    tick(); tick(); tick();
    checks++; if (bus.data_out !== 8'h00) begin errors++; $display("FAIL rst_flag_early: got %0h expected 00", bus.data_out); end
    tick();
    checks++; if (bus.data_out !== 8'hFF || bus.hit !== 1'b1) begin errors++; $display("FAIL rst_flag_d0: got %0h/%0b expected ff/1", bus.data_out, bus.hit); end
    bus.address = 8'hD1;
    tick();
    checks++; if (bus.data_out !== 8'hFF) begin errors++; $display("FAIL rst_flag_d1: got %0h expected ff", bus.data_out); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rst_irq_unmasked: got %0b expected 0", irq); end
  endtask

  task automatic test_output();
    bus.address = 8'hE3; bus.data_in = 8'hA5; bus.write = 1'b1;
    tick();
    checks++; if (port_out[3*8 +: 8] !== 8'hA5) begin errors++; $display("FAIL out_port3: got %0h expected a5", port_out[3*8 +: 8]); end
    checks++; if (bus.data_out !== 8'h00 || bus.hit !== 1'b1) begin errors++; $display("FAIL out_read_before_write: got %0h/%0b expected 00/1", bus.data_out, bus.hit); end
    bus.write = 1'b0;
    tick();
    checks++; if (bus.data_out !== 8'hA5 || bus.hit !== 1'b1) begin errors++; $display("FAIL out_readback: got %0h/%0b expected a5/1", bus.data_out, bus.hit); end
    bus.address = 8'h40;
    tick();
    checks++; if (bus.data_out !== 8'h00 || bus.hit !== 1'b0) begin errors++; $display("FAIL out_unmapped: got %0h/%0b expected 00/0", bus.data_out, bus.hit); end
    bus.address = 8'hF3; bus.data_in = 8'h55; bus.write = 1'b1;
    tick();
    bus.write = 1'b0;
    checks++; if (port_out[3*8 +: 8] !== 8'hA5 || port_out[0 +: 8] !== 8'h00) begin errors++; $display("FAIL out_in_write_ignored: got %0h expected a5,00", port_out[31:0]); end
  endtask

  task automatic test_input_sync();
    port_in = '0;
    tick(); tick(); tick(); tick();
    bus.address = 8'hD0; bus.data_in = 8'hFF; bus.write = 1'b1;
    tick();
    bus.address = 8'hD1;
    tick();
    bus.write = 1'b0;
    tick();
    checks++; if (bus.data_out !== 8'h00) begin errors++; $display("FAIL sync_cleared: got %0h expected 00", bus.data_out); end
    port_in[9*8 +: 8] = 8'h3C;
    bus.address = 8'hF9;
    tick(); tick();
    checks++; if (bus.data_out !== 8'h00) begin errors++; $display("FAIL sync_early: got %0h expected 00", bus.data_out); end
    tick();
    checks++; if (bus.data_out !== 8'h3C || bus.hit !== 1'b1) begin errors++; $display("FAIL sync_in9: got %0h/%0b expected 3c/1", bus.data_out, bus.hit); end
    bus.address = 8'hD1;
    tick();
    checks++; if (bus.data_out !== 8'h02) begin errors++; $display("FAIL sync_flag9: got %0h expected 02", bus.data_out); end
  endtask

  task automatic test_w1c_collision();
    port_in[9*8 +: 8] = 8'h11;
    tick(); tick();
    bus.address = 8'hD1; bus.data_in = 8'h02; bus.write = 1'b1;
    tick();
    bus.write = 1'b0;
    tick();
    checks++; if (bus.data_out !== 8'h02) begin errors++; $display("FAIL w1c_collision: got %0h expected 02", bus.data_out); end
    bus.write = 1'b1;
    tick();
    bus.write = 1'b0;
    tick();
    checks++; if (bus.data_out !== 8'h00) begin errors++; $display("FAIL w1c_clear: got %0h expected 00", bus.data_out); end
  endtask

  task automatic test_irq();
    port_in[0 +: 8] = 8'h01;
    bus.address = 8'hD0;
    tick(); tick(); tick(); tick();
    checks++; if (bus.data_out !== 8'h01) begin errors++; $display("FAIL irq_flag0: got %0h expected 01", bus.data_out); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_masked: got %0b expected 0", irq); end
    bus.address = 8'hD8; bus.data_in = 8'h01; bus.write = 1'b1;
    tick();
    bus.write = 1'b0;
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_mask_edge: got %0b expected 0", irq); end
    tick();
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_set: got %0b expected 1", irq); end
    checks++; if (bus.data_out !== 8'h01) begin errors++; $display("FAIL irq_mask_read: got %0h expected 01", bus.data_out); end
    bus.address = 8'hD0; bus.data_in = 8'h01; bus.write = 1'b1;
    tick();
    bus.write = 1'b0;
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_clear_edge: got %0b expected 1", irq); end
    tick();
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_cleared: got %0b expected 0", irq); end
  endtask

  task automatic test_param_sweep();
    port_in2[16*16 +: 64] = 64'h0001_0002_0003_0004;
    tick(); tick(); tick(); tick();
    bus2.address = 8'hD9; bus2.data_in = 16'hFFFF; bus2.write = 1'b1;
    tick();
    bus2.write = 1'b0;
    tick();
    checks++; if (bus2.data_out !== 16'h000F || bus2.hit !== 1'b1) begin errors++; $display("FAIL sweep_mask_w1: got %0h/%0b expected 000f/1", bus2.data_out, bus2.hit); end
    bus2.address = 8'hD1;
    tick();
    checks++; if (bus2.data_out !== 16'h000F) begin errors++; $display("FAIL sweep_flag_w1: got %0h expected 000f", bus2.data_out); end
    checks++; if (irq2 !== 1'b1) begin errors++; $display("FAIL sweep_irq: got %0b expected 1", irq2); end
    bus2.address = 8'hE4; bus2.data_in = 16'h1234; bus2.write = 1'b1;
    tick();
    bus2.write = 1'b0;
    checks++; if (port_out2 !== 64'h0) begin errors++; $display("FAIL sweep_e4_ignored: got %0h expected 0", port_out2); end
    tick();
    checks++; if (bus2.data_out !== 16'h0000 || bus2.hit !== 1'b0) begin errors++; $display("FAIL sweep_e4_read: got %0h/%0b expected 0/0", bus2.data_out, bus2.hit); end
    bus2.address = 8'hE3; bus2.data_in = 16'hBEEF; bus2.write = 1'b1;
    tick();
    bus2.write = 1'b0;
    checks++; if (port_out2 !== 64'hBEEF_0000_0000_0000) begin errors++; $display("FAIL sweep_e3: got %0h expected beef000000000000", port_out2); end
  endtask

  task automatic test_mid_reset();
    bus2.address = 8'hE2; bus2.data_in = 16'h7777; bus2.write = 1'b1;
    bus.address  = 8'hE5; bus.data_in  = 8'h5A;    bus.write  = 1'b1;
    tick();
    checks++; if (port_out2[2*16 +: 16] !== 16'h7777 || port_out[5*8 +: 8] !== 8'h5A) begin errors++; $display("FAIL mid_pre: got %0h,%0h expected 7777,5a", port_out2[2*16 +: 16], port_out[5*8 +: 8]); end
    #2;
    reset = 1'b0;
    #1;
    checks++; if (port_out2 !== 64'h0 || port_out !== '0) begin errors++; $display("FAIL mid_async_clear: got %0h,%0h expected 0,0", port_out2, port_out); end
    checks++; if (irq !== 1'b0 || irq2 !== 1'b0 || bus.hit !== 1'b0) begin errors++; $display("FAIL mid_async_misc: got irq=%0b irq2=%0b hit=%0b expected 0", irq, irq2, bus.hit); end
    @(posedge clk);
    #1;
    reset = 1'b1;
    bus.write = 1'b0;
    bus2.write = 1'b0;
    tick();
    checks++; if (bus2.data_out !== 16'h0000 || bus2.hit !== 1'b1) begin errors++; $display("FAIL mid_post_e2: got %0h/%0b expected 0/1", bus2.data_out, bus2.hit); end
    checks++; if (bus.data_out !== 8'h00 || port_out !== '0) begin errors++; $display("FAIL mid_post_e5: got %0h,%0h expected 0,0", bus.data_out, port_out); end
  endtask

  initial begin
    test_reset();
    test_output();
    test_input_sync();
    test_w1c_collision();
    test_irq();
    test_param_sweep();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
